// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg
//   Shared types and constants for the ROM burst reader:
//   - state_e        : burst FSM states
//   - FIFO_DEPTH     : beats the capture FIFO can hold (also the issue credit)
//   - CNT_WD         : width of the FIFO occupancy count
//   - credit_ok()    : issue permission from FIFO occupancy, in-flight read and pop
package rom_reader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_WD     = $clog2(FIFO_DEPTH + 1);

  // A read issued now lands in the FIFO two edges later. Occupancy seen at that
  // point is (count + inflight - pop) from this cycle, plus this new beat, so
  // issuing is safe while that projected figure stays below FIFO_DEPTH. The pop
  // term is what allows one beat per cycle when downstream is always ready.
  function automatic logic credit_ok(input logic [CNT_WD-1:0] count,
                                     input logic              inflight,
                                     input logic              pop);
    return (int'(count) + int'(inflight)) < (FIFO_DEPTH + int'(pop));
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// rom_rd_fifo
//   Two-entry synchronous FIFO holding captured ROM beats until downstream
//   takes them. The head is a mux of registers, so it is stable until popped.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_data this cycle (must not be full unless popping)
//   push_data    entry to store
//   pop          remove head this cycle (must not be empty)
//   head         current head entry
//   full, empty  occupancy flags
//   count        number of stored entries
module rom_rd_fifo
  import rom_reader_pkg::*;
#(
  parameter int WIDTH = 129
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic              full,
  output logic              empty,
  output logic [CNT_WD-1:0] count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  // NOTE: storage is only two words and the head must read zero after reset,
  // so it is cleared here; a deep RAM-style array would be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      // Push while full is only legal with a pop; then wr_ptr == rd_ptr and
      // the popped head is overwritten after it has been presented.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + CNT_WD'(push) - CNT_WD'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_WD'(FIFO_DEPTH));

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//   Read-side initiator for a synchronous ROM with 1-cycle read latency.
//   Accepts a burst (start word address, beats-1), issues one ROM read per
//   cycle within FIFO credit, captures returning words into a 2-entry FIFO and
//   presents them on a valid/ready stream with a last flag.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        burst request handshake
//   req_addr, req_len          start word address, beat count minus one
//   rom_addr, rom_rd_en        ROM read port
//   rom_r_data                 ROM data, valid the cycle after rom_rd_en
//   dout_valid/dout_ready      output beat handshake
//   dout_data, dout_last       beat payload, final-beat flag
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 128,
  parameter int ROM_DEPTH = 2048,
  parameter int LEN_WD    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_WD-1:0] req_addr,
  input  logic [LEN_WD-1:0]  req_len,
  output logic [ADDR_WD-1:0] rom_addr,
  output logic               rom_rd_en,
  input  logic [DATA_WD-1:0] rom_r_data,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [DATA_WD-1:0] dout_data,
  output logic               dout_last
);

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic               last;
  } beat_t;

  localparam logic [ADDR_WD-1:0] ADDR_MASK = ADDR_WD'(ROM_DEPTH - 1);
  localparam logic [ADDR_WD-1:0] ADDR_ONE  = ADDR_WD'(1);
  localparam logic [LEN_WD:0]    CNT_ONE   = (LEN_WD + 1)'(1);

  state_e             state;
  logic [ADDR_WD-1:0] cur_addr;
  // One bit wider than req_len so a full 2^LEN_WD-beat burst still compares.
  logic [LEN_WD:0]    beat_cnt;
  logic [LEN_WD:0]    last_idx;
  logic               inflight;
  logic               inflight_last;

  logic               issue;
  logic               pop;
  logic               is_last_beat;
  logic [CNT_WD-1:0]  fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  beat_t              push_beat;
  beat_t              head_beat;

  assign pop          = dout_valid & dout_ready;
  assign issue        = (state == BURST) && credit_ok(fifo_count, inflight, pop);
  assign is_last_beat = (beat_cnt == last_idx);

  assign req_ready = (state == IDLE);
  assign rom_rd_en = issue;
  assign rom_addr  = cur_addr;

  // rom_r_data reaches FIFO storage only on inflight pushes, so an undriven
  // ROM bus in other cycles never propagates.
  assign push_beat = '{data: rom_r_data, last: inflight_last};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_addr      <= '0;
      beat_cnt      <= '0;
      last_idx      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue & is_last_beat;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr <= req_addr & ADDR_MASK;
            last_idx <= {1'b0, req_len};
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            cur_addr <= (cur_addr + ADDR_ONE) & ADDR_MASK;
            beat_cnt <= beat_cnt + CNT_ONE;
            if (is_last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rom_rd_fifo #(
    .WIDTH($bits(beat_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(push_beat),
    .pop      (pop),
    .head     (head_beat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign dout_valid = ~fifo_empty;
  assign dout_data  = head_beat.data;
  assign dout_last  = head_beat.last;

  // Credit keeps the FIFO from overflowing; full is informational only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
